// File: rtl/oxi_pkg.sv
// rtl/oxi_pkg.sv - shared widths, state encoding and channel settings for the LED phase sequencer
package oxi_pkg;
    localparam int ADC_W = 8;
    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int DRV_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RED_SETTLE,
        RED_SAMPLE,
        IR_SETTLE,
        IR_SAMPLE,
        AMB_SETTLE,
        AMB_SAMPLE,
        WAIT_FRAME
    } state_t;

    typedef struct packed {
        logic [DC_W-1:0]  dc;
        logic [PGA_W-1:0] pga;
    } chan_cfg_t;

    function automatic logic is_sample(input state_t s);
        return (s == RED_SAMPLE) || (s == IR_SAMPLE) || (s == AMB_SAMPLE);
    endfunction
endpackage

// File: rtl/phase_averager.sv
// rtl/phase_averager.sv - clear/accumulate/shift averager over a power-of-two ADC window
module phase_averager
    import oxi_pkg::*;
#(
    parameter int SAMPLE_CYC = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] avg
);
    localparam int SHIFT = $clog2(SAMPLE_CYC);
    localparam int ACC_W = ADC_W + SHIFT;

    if ((SAMPLE_CYC < 1) || (SAMPLE_CYC > 64) || ((1 << SHIFT) != SAMPLE_CYC)) begin : g_bad_sample
        $error("SAMPLE_CYC must be a power of two in 1..64");
    end

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;

    // avg includes the current sample so the last window cycle can be latched directly
    assign w_sum = r_acc + ACC_W'(din);
    assign avg   = ADC_W'(w_sum >> SHIFT);

    always_ff @(posedge CLK) begin
        if (rst || clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum;
        end
    end
endmodule

// File: rtl/led_phase_sequencer.sv
// rtl/led_phase_sequencer.sv - RED/IR/ambient LED phase sequencer with per-phase ADC averaging
module led_phase_sequencer
    import oxi_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_CYC = 4,
    parameter int FRAME_CYC  = 1000
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             enable,
    input  logic [DC_W-1:0]  red_dc,
    input  logic [PGA_W-1:0] red_pga,
    input  logic [DC_W-1:0]  ir_dc,
    input  logic [PGA_W-1:0] ir_pga,
    input  logic [DRV_W-1:0] led_drive_cfg,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DRV_W-1:0] LED_DRIVE,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] AMB_ADC_Value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);
    localparam int PH_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int FR_W   = $clog2(FRAME_CYC);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] SAMPLE_LAST = PH_W'(SAMPLE_CYC - 1);
    localparam logic [FR_W-1:0] FRAME_LAST  = FR_W'(FRAME_CYC - 1);

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("SETTLE_CYC must be at least 1");
    end
    if (FRAME_CYC < 3 * (SETTLE_CYC + SAMPLE_CYC) + 1) begin : g_bad_frame
        $error("FRAME_CYC too short for three phases plus a frame boundary");
    end

    state_t           r_state, w_next_state;
    logic [PH_W-1:0]  r_phase_cnt;
    logic [FR_W-1:0]  r_frame_cnt;
    chan_cfg_t        r_red_cfg, r_ir_cfg, w_red_cfg, w_ir_cfg;
    logic [DRV_W-1:0] r_drive, w_drive;
    logic             w_frame_start, w_settle_done, w_sample_done;
    logic             w_result_load, w_avg_clr, w_avg_en;
    logic [ADC_W-1:0] w_avg, r_red_hold, r_ir_hold;
    logic             w_led_red, w_led_ir, w_busy;
    logic [DRV_W-1:0] w_led_drive;
    logic [DC_W-1:0]  w_dc;
    logic [PGA_W-1:0] w_pga;

    always_comb begin
        w_settle_done = (r_phase_cnt == SETTLE_LAST);
        w_sample_done = (r_phase_cnt == SAMPLE_LAST);
        w_frame_start = enable && ((r_state == IDLE) ||
                                   ((r_state == WAIT_FRAME) && (r_frame_cnt == '0)));
        w_next_state  = r_state;
        case (r_state)
            IDLE:       if (enable)        w_next_state = RED_SETTLE;
            RED_SETTLE: if (w_settle_done) w_next_state = RED_SAMPLE;
            RED_SAMPLE: if (w_sample_done) w_next_state = IR_SETTLE;
            IR_SETTLE:  if (w_settle_done) w_next_state = IR_SAMPLE;
            IR_SAMPLE:  if (w_sample_done) w_next_state = AMB_SETTLE;
            AMB_SETTLE: if (w_settle_done) w_next_state = AMB_SAMPLE;
            AMB_SAMPLE: if (w_sample_done) w_next_state = WAIT_FRAME;
            WAIT_FRAME: if (r_frame_cnt == '0) w_next_state = enable ? RED_SETTLE : IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Shadow values as they will be after this edge, so the first RED cycle already sees new config
    always_comb begin
        w_red_cfg = r_red_cfg;
        w_ir_cfg  = r_ir_cfg;
        w_drive   = r_drive;
        if (w_frame_start) begin
            w_red_cfg = '{dc: red_dc, pga: red_pga};
            w_ir_cfg  = '{dc: ir_dc,  pga: ir_pga};
            w_drive   = led_drive_cfg;
        end
    end

    always_comb begin
        w_led_red   = 1'b0;
        w_led_ir    = 1'b0;
        w_dc        = '0;
        w_pga       = '0;
        w_busy      = (w_next_state != IDLE);
        w_led_drive = (w_next_state == IDLE) ? '0 : w_drive;
        case (w_next_state)
            RED_SETTLE, RED_SAMPLE: begin
                w_led_red = 1'b1;
                w_dc      = w_red_cfg.dc;
                w_pga     = w_red_cfg.pga;
            end
            IR_SETTLE, IR_SAMPLE: begin
                w_led_ir = 1'b1;
                w_dc     = w_ir_cfg.dc;
                w_pga    = w_ir_cfg.pga;
            end
            AMB_SETTLE, AMB_SAMPLE: begin
                w_dc  = w_red_cfg.dc;
                w_pga = w_red_cfg.pga;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase_cnt <= '0;
            r_frame_cnt <= '0;
            r_red_cfg   <= '0;
            r_ir_cfg    <= '0;
            r_drive     <= '0;
            LED_RED     <= 1'b0;
            LED_IR      <= 1'b0;
            LED_DRIVE   <= '0;
            DC_Comp     <= '0;
            PGA_Gain    <= '0;
            busy        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_red_cfg <= w_red_cfg;
            r_ir_cfg  <= w_ir_cfg;
            r_drive   <= w_drive;
            if ((w_next_state != r_state) || (r_state == IDLE) || (r_state == WAIT_FRAME)) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + 1'b1;
            end
            if (w_next_state == IDLE) begin
                r_frame_cnt <= '0;
            end else if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            LED_RED   <= w_led_red;
            LED_IR    <= w_led_ir;
            LED_DRIVE <= w_led_drive;
            DC_Comp   <= w_dc;
            PGA_Gain  <= w_pga;
            busy      <= w_busy;
        end
    end

    assign w_avg_clr     = is_sample(w_next_state) && (w_next_state != r_state);
    assign w_avg_en      = is_sample(r_state);
    assign w_result_load = (r_state == AMB_SAMPLE) && w_sample_done;

    phase_averager #(
        .SAMPLE_CYC (SAMPLE_CYC)
    ) u_avg (
        .CLK (CLK),
        .rst (rst),
        .clr (w_avg_clr),
        .en  (w_avg_en),
        .din (ADC),
        .avg (w_avg)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_red_hold    <= '0;
            r_ir_hold     <= '0;
            RED_ADC_Value <= '0;
            IR_ADC_Value  <= '0;
            AMB_ADC_Value <= '0;
            out_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if ((r_state == RED_SAMPLE) && w_sample_done) r_red_hold <= w_avg;
            if ((r_state == IR_SAMPLE) && w_sample_done)  r_ir_hold  <= w_avg;
            // Ambient average bypasses its holding register; it completes on this very edge
            if (w_result_load) begin
                RED_ADC_Value <= r_red_hold;
                IR_ADC_Value  <= r_ir_hold;
                AMB_ADC_Value <= w_avg;
                out_valid     <= 1'b1;
                overrun       <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_led_phase_sequencer.sv
// tb/tb_led_phase_sequencer.sv - directed self-checking bench for led_phase_sequencer
module tb_led_phase_sequencer;
    localparam int SETTLE = 2;
    localparam int SAMPLE = 4;
    localparam int FRAME  = 32;

    logic       CLK = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] red_dc, ir_dc;
    logic [3:0] red_pga, ir_pga, led_drive_cfg;
    logic [7:0] ADC;
    logic       LED_RED, LED_IR;
    logic [3:0] LED_DRIVE, PGA_Gain;
    logic [6:0] DC_Comp;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, AMB_ADC_Value;
    logic       out_valid, out_ready, overrun, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    led_phase_sequencer #(
        .SETTLE_CYC (SETTLE),
        .SAMPLE_CYC (SAMPLE),
        .FRAME_CYC  (FRAME)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .enable        (enable),
        .red_dc        (red_dc),
        .red_pga       (red_pga),
        .ir_dc         (ir_dc),
        .ir_pga        (ir_pga),
        .led_drive_cfg (led_drive_cfg),
        .ADC           (ADC),
        .LED_RED       (LED_RED),
        .LED_IR        (LED_IR),
        .LED_DRIVE     (LED_DRIVE),
        .DC_Comp       (DC_Comp),
        .PGA_Gain      (PGA_Gain),
        .RED_ADC_Value (RED_ADC_Value),
        .IR_ADC_Value  (IR_ADC_Value),
        .AMB_ADC_Value (AMB_ADC_Value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overrun       (overrun),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rep4(input logic [7:0] v);
        return {4{v}};
    endfunction

    // k counts cycles of a frame from 1 (first RED_SETTLE cycle); k=32 is the frame boundary cycle
    task automatic do_frame(input int mode, input logic [31:0] rv, input logic [31:0] iv,
                            input logic [31:0] av, input logic [7:0] er, input logic [7:0] ei,
                            input logic [7:0] ea, input logic [6:0] dc_exp);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (k >= 3 && k <= 6)        ADC = rv[8*(k-3) +: 8];
            else if (k >= 9 && k <= 12)  ADC = iv[8*(k-9) +: 8];
            else if (k >= 15 && k <= 18) ADC = av[8*(k-15) +: 8];
            else                         ADC = 8'hEE;

            if (k == 1) begin
                chk("red_led_on", LED_RED, 1);
                chk("ir_led_off", LED_IR, 0);
                chk("busy_run", busy, 1);
                chk("red_dc", DC_Comp, dc_exp);
                chk("red_pga", PGA_Gain, 3);
                chk("drive_run", LED_DRIVE, 11);
            end
            if (k == 6)  chk("red_led_last", LED_RED, 1);
            if (k == 7) begin
                chk("red_led_off", LED_RED, 0);
                chk("ir_led_on", LED_IR, 1);
                chk("ir_dc", DC_Comp, 20);
                chk("ir_pga", PGA_Gain, 6);
            end
            if (k == 12) chk("ir_led_last", LED_IR, 1);
            if (k == 13) begin
                chk("amb_red_off", LED_RED, 0);
                chk("amb_ir_off", LED_IR, 0);
                chk("amb_dc", DC_Comp, dc_exp);
                chk("amb_pga", PGA_Gain, 3);
            end
            if (k == 19) begin
                chk("valid_res", out_valid, 1);
                chk("overrun", overrun, (mode == 3) ? 1 : 0);
                chk("red_avg", RED_ADC_Value, er);
                chk("ir_avg", IR_ADC_Value, ei);
                chk("amb_avg", AMB_ADC_Value, ea);
                chk("wait_dc", DC_Comp, 0);
                chk("wait_pga", PGA_Gain, 0);
                chk("wait_drive", LED_DRIVE, 11);
                chk("wait_leds", {LED_RED, LED_IR}, 0);
            end

            if ((mode == 0 || mode == 1 || mode == 5) && k == 18) chk("valid_pre", out_valid, 0);
            if ((mode == 0 || mode == 1 || mode == 5) && k == 20) chk("valid_acc", out_valid, 0);
            if (mode == 1 && k == 3) red_dc = 7'd9;
            if (mode == 2 && k == 25) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_red", RED_ADC_Value, 50);
            end
            if (mode == 3 && k == 18) begin
                chk("ovr_pre_valid", out_valid, 1);
                chk("ovr_pre_red", RED_ADC_Value, 50);
            end
            if (mode == 3 && k == 20) begin
                chk("ovr_pulse_end", overrun, 0);
                chk("ovr_valid_held", out_valid, 1);
            end
            if (mode == 4 && k == 18) begin
                chk("same_pre_valid", out_valid, 1);
                chk("same_pre_red", RED_ADC_Value, 80);
                out_ready = 1'b1;
            end
            if (mode == 4 && k == 19) out_ready = 1'b0;
            if (mode == 4 && k == 20) begin
                chk("same_valid_held", out_valid, 1);
                out_ready = 1'b1;
            end
            if (mode == 4 && k == 21) chk("same_valid_clr", out_valid, 0);
            if (mode == 5 && k == 7)  enable = 1'b0;
            if (mode == 5 && k == FRAME) begin
                chk("bound_busy", busy, 1);
                chk("bound_drive", LED_DRIVE, 11);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; out_ready = 1'b1; ADC = 8'h00;
        red_dc = 7'd5; red_pga = 4'd3; ir_dc = 7'd20; ir_pga = 4'd6; led_drive_cfg = 4'd11;
        repeat (3) step();
        chk("rst_leds", {LED_RED, LED_IR}, 0);
        chk("rst_drive", LED_DRIVE, 0);
        chk("rst_dc", DC_Comp, 0);
        chk("rst_pga", PGA_Gain, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_red_val", RED_ADC_Value, 0);
        rst = 1'b0;

        do_frame(1, rep4(8'd100), rep4(8'd200), rep4(8'd10), 8'd100, 8'd200, 8'd10, 7'd5);
        do_frame(0, {8'd41, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, rep4(8'd255),
                 8'd25, 8'd2, 8'd255, 7'd9);
        out_ready = 1'b0;
        do_frame(2, rep4(8'd50), rep4(8'd60), rep4(8'd70), 8'd50, 8'd60, 8'd70, 7'd9);
        do_frame(3, rep4(8'd80), rep4(8'd90), rep4(8'd0), 8'd80, 8'd90, 8'd0, 7'd9);
        do_frame(4, rep4(8'd7), rep4(8'd8), rep4(8'd9), 8'd7, 8'd8, 8'd9, 7'd9);
        do_frame(5, rep4(8'd11), rep4(8'd22), rep4(8'd33), 8'd11, 8'd22, 8'd33, 7'd9);

        step();
        chk("idle_busy", busy, 0);
        chk("idle_drive", LED_DRIVE, 0);
        chk("idle_leds", {LED_RED, LED_IR}, 0);
        chk("idle_valid", out_valid, 0);
        step();
        chk("idle_stay", busy, 0);

        enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            ADC = 8'd77;
            if (k == 1) chk("restart_red", LED_RED, 1);
            if (k == 9) begin
                chk("pre_rst_ir", LED_IR, 1);
                rst = 1'b1;
            end
        end
        step();
        chk("mid_rst_ir", LED_IR, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drive", LED_DRIVE, 0);
        chk("mid_rst_dc", DC_Comp, 0);
        chk("mid_rst_pga", PGA_Gain, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_red_val", RED_ADC_Value, 0);
        rst = 1'b0;
        do_frame(0, rep4(8'd120), rep4(8'd130), rep4(8'd140), 8'd120, 8'd130, 8'd140, 7'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
